// File: rtl/mux8_select_sequencer.sv
// mux8_select_sequencer: byte-to-serial driver for an external 8:1 bit mux (i/s/y).
// Define SEQ_PARITY_EN to append an even-parity beat after the eighth data bit.
module mux8_select_sequencer #(
   parameter bit LSB_FIRST   = 1'b1,
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] mux_i,
   output logic [2:0] mux_s,
   input  logic       mux_y,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_bit,
   output logic       ser_last,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_OUT
`ifdef SEQ_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   localparam logic [3:0] HOLD_CNT = 4'(HOLD_CYCLES);
   localparam logic [2:0] SEL_FIRST = LSB_FIRST ? 3'd0 : 3'd7;
   // Adding 7 in three bits is a decrement; the select never wraps because the 8th beat stops stepping.
   localparam logic [2:0] SEL_STEP  = LSB_FIRST ? 3'd1 : 3'd7;

   state_t     r_state;
   logic [7:0] r_mux_i;
   logic [2:0] r_mux_s;
   logic [3:0] r_cnt;
   logic [2:0] r_beat;
   logic       r_ser_valid;
   logic       r_ser_bit;
   logic       r_ser_last;
`ifdef SEQ_PARITY_EN
   logic       r_parity;
`endif

   logic       w_accept;
   logic       w_take;
   logic       w_last_bit;

   assign w_accept   = in_valid && (r_state == S_IDLE);
   assign w_take     = r_ser_valid && ser_ready;
   assign w_last_bit = (r_beat == 3'd7);

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign mux_i     = r_mux_i;
   assign mux_s     = r_mux_s;
   assign ser_valid = r_ser_valid;
   assign ser_bit   = r_ser_bit;
   assign ser_last  = r_ser_last;

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mux_i     <= 8'd0;
         r_mux_s     <= 3'd0;
         r_cnt       <= 4'd0;
         r_beat      <= 3'd0;
         r_ser_valid <= 1'b0;
         r_ser_bit   <= 1'b0;
         r_ser_last  <= 1'b0;
`ifdef SEQ_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mux_i <= in_data;
                  r_mux_s <= SEL_FIRST;
                  r_cnt   <= HOLD_CNT;
                  r_beat  <= 3'd0;
`ifdef SEQ_PARITY_EN
                  r_parity <= 1'b0;
`endif
                  r_state <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_ser_bit   <= mux_y;
                  r_ser_valid <= 1'b1;
`ifdef SEQ_PARITY_EN
                  r_parity    <= r_parity ^ mux_y;
                  r_ser_last  <= 1'b0;
`else
                  r_ser_last  <= w_last_bit;
`endif
                  r_state     <= S_OUT;
               end
            end

            S_OUT: begin
               if (w_take) begin
                  if (!w_last_bit) begin
                     r_ser_valid <= 1'b0;
                     r_ser_last  <= 1'b0;
                     r_mux_s     <= r_mux_s + SEL_STEP;
                     r_cnt       <= HOLD_CNT;
                     r_beat      <= r_beat + 3'd1;
                     r_state     <= S_SETTLE;
                  end else begin
`ifdef SEQ_PARITY_EN
                     r_ser_valid <= 1'b1;
                     r_ser_bit   <= r_parity;
                     r_ser_last  <= 1'b1;
                     r_state     <= S_PARITY;
`else
                     r_ser_valid <= 1'b0;
                     r_ser_last  <= 1'b0;
                     r_state     <= S_IDLE;
`endif
                  end
               end
            end

`ifdef SEQ_PARITY_EN
            S_PARITY: begin
               if (w_take) begin
                  r_ser_valid <= 1'b0;
                  r_ser_last  <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
`endif

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_select_sequencer.sv
// Bench for mux8_select_sequencer: three configurations, each driving a behavioural 8:1 mux,
// checked beat by beat against a word-level model of the serial stream.
module tb_mux8_select_sequencer;

   localparam int N = 3;
`ifdef SEQ_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid  [N];
   logic       in_ready  [N];
   logic [7:0] in_data   [N];
   logic [7:0] mux_i     [N];
   logic [2:0] mux_s     [N];
   logic       mux_y     [N];
   logic       ser_valid [N];
   logic       ser_ready [N];
   logic       ser_bit   [N];
   logic       ser_last  [N];
   logic       busy      [N];

   int n_checks = 0;
   int n_fail   = 0;
   int elapsed  = 0;

   function automatic int lsb_of(input int k);
      return (k == 1) ? 0 : 1;
   endfunction

   function automatic int hold_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction

   mux8_select_sequencer #(.LSB_FIRST(1), .HOLD_CYCLES(1)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .mux_i(mux_i[0]), .mux_s(mux_s[0]), .mux_y(mux_y[0]),
      .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_bit(ser_bit[0]),
      .ser_last(ser_last[0]), .busy(busy[0]));

   mux8_select_sequencer #(.LSB_FIRST(0), .HOLD_CYCLES(1)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .mux_i(mux_i[1]), .mux_s(mux_s[1]), .mux_y(mux_y[1]),
      .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_bit(ser_bit[1]),
      .ser_last(ser_last[1]), .busy(busy[1]));

   mux8_select_sequencer #(.LSB_FIRST(1), .HOLD_CYCLES(3)) u_dut_hold3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .mux_i(mux_i[2]), .mux_s(mux_s[2]), .mux_y(mux_y[2]),
      .ser_valid(ser_valid[2]), .ser_ready(ser_ready[2]), .ser_bit(ser_bit[2]),
      .ser_last(ser_last[2]), .busy(busy[2]));

   // Behavioural 8:1 muxes closing the loop around each sequencer.
   assign mux_y[0] = mux_i[0][mux_s[0]];
   assign mux_y[1] = mux_i[1][mux_s[1]];
   assign mux_y[2] = mux_i[2][mux_s[2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      elapsed++;
   endtask

   task automatic check_reset_outputs(input int k);
      check("rst_mux_i",     mux_i[k],     8'd0);
      check("rst_mux_s",     mux_s[k],     3'd0);
      check("rst_ser_valid", ser_valid[k], 1'b0);
      check("rst_ser_bit",   ser_bit[k],   1'b0);
      check("rst_ser_last",  ser_last[k],  1'b0);
      check("rst_busy",      busy[k],      1'b0);
      check("rst_in_ready",  in_ready[k],  1'b1);
   endtask

   // Offers one word and follows it through every beat. Called and returns at a negedge.
   // abort_after > 0 pulses reset after that many handshakes.
   task automatic run_word(input int k, input logic [7:0] word, input int stall_beat,
                           input int stall_len, input bit rand_stall, input bit keep_valid,
                           input logic [7:0] next_word, input int abort_after);
      int lsb, hold, nbeats, waited, nst, stalls, idx;
      bit exp_bit, exp_last;
      lsb    = lsb_of(k);
      hold   = hold_of(k);
      nbeats = 8 + PAR;
      stalls = 0;

      check("accept_in_ready", in_ready[k], 1'b1);
      in_valid[k] = 1'b1;
      in_data[k]  = word;
      tick();
      elapsed = 0;
      in_valid[k] = keep_valid;
      in_data[k]  = keep_valid ? next_word : 8'($urandom);
      check("accept_busy", busy[k], 1'b1);

      for (int b = 0; b < nbeats; b++) begin
         waited = 0;
         while (!ser_valid[k] && waited < 64) begin
            tick();
            waited++;
         end
         if (!ser_valid[k]) begin
            check("ser_valid_timeout", 32'd0, 32'd1);
            return;
         end
         check("beat_latency", waited, (b == 8) ? 0 : hold);

         if (b < 8) begin
            idx     = lsb ? b : 7 - b;
            exp_bit = word[idx];
         end else begin
            idx     = lsb ? 7 : 0;
            exp_bit = ^word;
         end
         exp_last = (b == nbeats - 1);

         check("ser_bit",   ser_bit[k],  exp_bit);
         check("mux_s",     mux_s[k],    idx);
         check("ser_last",  ser_last[k], exp_last);
         check("mux_i",     mux_i[k],    word);
         check("beat_busy", busy[k],     1'b1);
         check("beat_in_ready", in_ready[k], 1'b0);

         nst = (b == stall_beat) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s < nst; s++) begin
            ser_ready[k] = 1'b0;
            tick();
            check("stall_valid", ser_valid[k], 1'b1);
            check("stall_bit",   ser_bit[k],   exp_bit);
            check("stall_mux_s", mux_s[k],     idx);
            check("stall_last",  ser_last[k],  exp_last);
         end
         stalls += nst;
         ser_ready[k] = 1'b1;
         tick();
         ser_ready[k] = 1'b0;

         if (b == abort_after - 1) begin
            in_valid[k] = 1'b0;
            rst_n = 1'b0;
            #1;
            check_reset_outputs(k);
            tick();
            check("abort_no_last", ser_last[k], 1'b0);
            rst_n = 1'b1;
            return;
         end
      end

      check("end_ser_valid", ser_valid[k], 1'b0);
      check("end_in_ready",  in_ready[k],  1'b1);
      check("end_busy",      busy[k],      1'b0);
      check("end_mux_s",     mux_s[k],     lsb ? 3'd7 : 3'd0);
      check("end_mux_i",     mux_i[k],     word);
      check("word_clocks",   elapsed,      8 * (hold + 1) + stalls + PAR);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = 8'd0;
         ser_ready[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) check_reset_outputs(k);
      rst_n = 1'b1;
      tick();

      // LSB-first, hold 1, no backpressure: 16 clocks per word.
      run_word(0, 8'b1111_0001, -1, 0, 1'b0, 1'b0, 8'h00, 0);
      // MSB-first sweep ends on select 0.
      run_word(1, 8'b1000_0000, -1, 0, 1'b0, 1'b0, 8'h00, 0);
      // Hold 3 with a 5-clock stall on the third beat.
      run_word(2, 8'h5A, 2, 5, 1'b0, 1'b0, 8'h00, 0);
      // in_valid left high across a word: the second word waits for in_ready.
      run_word(0, 8'h0F, -1, 0, 1'b0, 1'b1, 8'hF0, 0);
      run_word(0, 8'hF0, -1, 0, 1'b0, 1'b0, 8'h00, 0);
      // Reset after the fourth beat, then a clean word.
      run_word(0, 8'hFF, -1, 0, 1'b0, 1'b0, 8'h00, 4);
      tick();
      run_word(0, 8'h81, -1, 0, 1'b0, 1'b0, 8'h00, 0);
      // Parity patterns (parity 0 and 1 when the beat exists).
      run_word(0, 8'b0111_1101, -1, 0, 1'b0, 1'b0, 8'h00, 0);
      run_word(0, 8'b0000_0010, -1, 0, 1'b0, 1'b0, 8'h00, 0);

      for (int k = 0; k < N; k++) begin
         for (int w = 0; w < 8; w++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_word(k, 8'($urandom), -1, 0, 1'b1, 1'b0, 8'h00, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
